mem_stage: RTL

- Memory-access pipeline stage plus MEM/WB pipeline register.
- Sits between the EXE/MEM register and the writeback block. It consumes the EXE-stage results, performs loads and stores through a request/ready handshake to an external data memory, and registers the results for writeback.
- Stalls the rest of the pipeline through `freeze` while an access is outstanding.

---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/mem_stage_mem_wb_reg.sv | 70 +++++++
 rtl/mem_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access pipeline stage:
//   - state_e        : FSM state encoding (IDLE, ACCESS)
//   - BASE_ADDR_DEF  : default byte address mapped to data-memory word 0
//   - ERR_DATA       : load data substituted when an access is force-completed
//   - REG_IDX_W      : register-index width
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
  localparam logic [31:0] ERR_DATA      = 32'hDEAD_BEEF;
  localparam int          REG_IDX_W     = 4;

endpackage : mem_stage_pkg

// File: rtl/mem_stage_mem_wb_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_reg
// MEM/WB pipeline register. While freeze_i is high a bubble is loaded
// (write-back and load flags cleared, data fields held) so a stalled
// instruction never writes back twice.
// Ports:
//   clk, rst             clock / asynchronous active-low reset
//   freeze_i             stall: load a bubble this edge
//   wb_en_i, mem_r_en_i  control flags from the memory stage
//   alu_result_i, dest_i ALU value and destination register
//   load_en_i            capture load_data_i into mem_result_o this edge
//   load_data_i          load data (memory read data or error pattern)
//   *_o                  registered copies of the above
// -----------------------------------------------------------------------------
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze_i,
  input  logic                 wb_en_i,
  input  logic                 mem_r_en_i,
  input  logic [31:0]          alu_result_i,
  input  logic [REG_IDX_W-1:0] dest_i,
  input  logic                 load_en_i,
  input  logic [31:0]          load_data_i,
  output logic                 wb_en_o,
  output logic                 mem_r_en_o,
  output logic [31:0]          alu_result_o,
  output logic [31:0]          mem_result_o,
  output logic [REG_IDX_W-1:0] dest_o
);

  logic                 wb_en_q;
  logic                 mem_r_en_q;
  logic [31:0]          alu_result_q;
  logic [31:0]          mem_result_q;
  logic [REG_IDX_W-1:0] dest_q;

  // Pipeline register: bubble on freeze, otherwise capture the stage results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      alu_result_q <= 32'd0;
      mem_result_q <= 32'd0;
      dest_q       <= {REG_IDX_W{1'b0}};
    end else if (freeze_i) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
    end else begin
      wb_en_q      <= wb_en_i;
      mem_r_en_q   <= mem_r_en_i;
      alu_result_q <= alu_result_i;
      dest_q       <= dest_i;
      if (load_en_i) begin
        mem_result_q <= load_data_i;
      end else begin
        mem_result_q <= mem_result_q;
      end
    end
  end

  assign wb_en_o      = wb_en_q;
  assign mem_r_en_o   = mem_r_en_q;
  assign alu_result_o = alu_result_q;
  assign mem_result_o = mem_result_q;
  assign dest_o       = dest_q;

endmodule : mem_wb_reg

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage plus MEM/WB register. Issues loads/stores to an
// external data memory over a req/ready handshake and stalls the front of the
// pipeline (freeze) until the access completes.
// Optional feature macro: MEM_TIMEOUT_EN -- when defined, an access that sees
// no mem_ready for TIMEOUT ACCESS cycles is force-completed, mem_error is set
// (sticky) and loads return 32'hDEAD_BEEF. Otherwise mem_error is tied 0.
// Ports:
//   clk, rst                       clock / asynchronous active-low reset
//   WB_EN, MEM_R_EN, MEM_W_EN      control from EXE/MEM register
//   ALU_result, Val_Rm, Dest       address/ALU value, store data, dest reg
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ready data-memory handshake
//   freeze                         stall PC/IF/ID/EXE and EXE/MEM register
//   WB_EN_out, MEM_R_EN_out,
//   ALU_result_out, Mem_result,
//   Dest_out                       MEM/WB register outputs
//   mem_error                      sticky timeout flag
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int          TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 WB_EN,
  input  logic                 MEM_R_EN,
  input  logic                 MEM_W_EN,
  input  logic [31:0]          ALU_result,
  input  logic [31:0]          Val_Rm,
  input  logic [REG_IDX_W-1:0] Dest,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready,
  output logic                 freeze,
  output logic                 WB_EN_out,
  output logic                 MEM_R_EN_out,
  output logic [31:0]          ALU_result_out,
  output logic [31:0]          Mem_result,
  output logic [REG_IDX_W-1:0] Dest_out,
  output logic                 mem_error
);

  state_e      state_q;
  logic        access_s;
  logic        active_s;
  logic        timeout_s;
  logic        freeze_s;
  logic        load_en_s;
  logic [31:0] load_data_s;
  logic [31:0] off_s;
  logic        unused_s;

  // Byte offset relative to the memory base; wraps modulo 2^32 by design.
  assign off_s    = ALU_result - BASE_ADDR;
  assign mem_addr = off_s[ADDR_W+1:2];
  assign unused_s = ^{off_s[31:ADDR_W+2], off_s[1:0]};

  assign access_s  = MEM_R_EN | MEM_W_EN;
  // Reset gates the request so an in-flight access is dropped at once even
  // though the held EXE/MEM inputs still ask for it.
  assign active_s  = rst & (access_s | (state_q == ST_ACCESS));
  assign mem_req   = active_s;
  assign mem_we    = MEM_W_EN;
  assign mem_wdata = Val_Rm;
  assign freeze_s  = active_s & ~mem_ready & ~timeout_s;
  assign freeze    = freeze_s;

  assign load_en_s   = MEM_R_EN & active_s & (mem_ready | timeout_s);
  assign load_data_s = timeout_s ? ERR_DATA : mem_rdata;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Last permitted ACCESS cycle without ready: complete it as an error.
  assign timeout_s = (state_q == ST_ACCESS) & ~mem_ready &
                     (cnt_q == CNT_W'(TIMEOUT - 1));

  // Wait counter (cleared while idle) and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
      err_q <= 1'b0;
    end else begin
      if (state_q == ST_ACCESS) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= {CNT_W{1'b0}};
      end
      if (timeout_s) begin
        err_q <= 1'b1;
      end else begin
        err_q <= err_q;
      end
    end
  end

  assign mem_error = err_q;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT != 0);
  assign timeout_s        = 1'b0;
  assign mem_error        = 1'b0;
`endif

  // Access FSM: IDLE issues the request; ACCESS waits for ready (or timeout).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access_s && !mem_ready) begin
            state_q <= ST_ACCESS;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (mem_ready || timeout_s) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_ACCESS;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .rst          (rst),
    .freeze_i     (freeze_s),
    .wb_en_i      (WB_EN),
    .mem_r_en_i   (MEM_R_EN),
    .alu_result_i (ALU_result),
    .dest_i       (Dest),
    .load_en_i    (load_en_s),
    .load_data_i  (load_data_s),
    .wb_en_o      (WB_EN_out),
    .mem_r_en_o   (MEM_R_EN_out),
    .alu_result_o (ALU_result_out),
    .mem_result_o (Mem_result),
    .dest_o       (Dest_out)
  );

endmodule : mem_stage
